// File: rtl/adc_pkg.sv
// Shared definitions for the ADC result transmitter: frame header, status-byte
// layout, framing FSM states and the word-to-byte sizing helper.
package adc_pkg;

    localparam logic [7:0] ADC_FRAME_HEADER   = 8'hA5;
    localparam int         STATUS_OVERRUN_BIT = 7;
    localparam int         STATUS_DIAP_LSB    = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT,
        ST_NEXT
    } txState_e;

    function automatic int bytesPerWord(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serializer. 'done' fires two cycles before the stop bit ends so
// the framing FSM's hand-off overhead overlaps the tail of the stop bit.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] byte_in,
    output logic       tx,
    output logic       done
);

    localparam int             CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CNT_DONE = CW'(CLKS_PER_BIT - 2);
    localparam logic [3:0]     STOP_BIT = 4'd9;

    logic          active_q;
    logic [8:0]    shift_q;
    logic [3:0]    bitIdx_q;
    logic [CW-1:0] clkCnt_q;
    logic          tx_q;

    // shift_q holds the data bits followed by the stop bit, emitted LSB first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            shift_q  <= '1;
            bitIdx_q <= '0;
            clkCnt_q <= '0;
            tx_q     <= 1'b1;
        end else if (!active_q) begin
            if (start) begin
                active_q <= 1'b1;
                shift_q  <= {1'b1, byte_in};
                bitIdx_q <= '0;
                clkCnt_q <= '0;
                tx_q     <= 1'b0;
            end
        end else if (clkCnt_q == CNT_LAST) begin
            clkCnt_q <= '0;
            if (bitIdx_q == STOP_BIT) begin
                active_q <= 1'b0;
                tx_q     <= 1'b1;
            end else begin
                tx_q     <= shift_q[0];
                shift_q  <= {1'b1, shift_q[8:1]};
                bitIdx_q <= bitIdx_q + 4'd1;
            end
        end else begin
            clkCnt_q <= clkCnt_q + CW'(1);
        end
    end

    assign done = active_q && (bitIdx_q == STOP_BIT) && (clkCnt_q == CNT_DONE);
    assign tx   = tx_q;

endmodule

// File: rtl/adc_result_tx.sv
// Frames each ADC measurement (header, status, two words, optional checksum) onto a UART.
// Define ADC_RESULT_TX_CHECKSUM_EN to append the modulo-256 checksum byte.
import adc_pkg::*;

module adc_result_tx #(
    parameter int DATA_WIDTH   = 24,
    parameter int DIAP_WIDTH   = 2,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  complete,
    input  logic [DATA_WIDTH-1:0] data_in_1,
    input  logic [DATA_WIDTH-1:0] data_in_2,
    input  logic [DIAP_WIDTH-1:0] diap,
    output logic                  tx,
    output logic                  busy,
    output logic                  overrun
);

    localparam int BPW       = bytesPerWord(DATA_WIDTH);
    localparam int WORD_BITS = 8 * BPW;
    localparam int PAY_BITS  = 2 * WORD_BITS;
    localparam int DATA_END  = 2 + 2 * BPW;
`ifdef ADC_RESULT_TX_CHECKSUM_EN
    localparam int NBYTES    = DATA_END + 1;
`else
    localparam int NBYTES    = DATA_END;
`endif
    localparam int                IDX_W        = $clog2(NBYTES + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX     = IDX_W'(NBYTES - 1);
    localparam logic [IDX_W-1:0]  DATA_END_IDX = IDX_W'(DATA_END);

    txState_e              state_q;
    logic [DATA_WIDTH-1:0] actD1_q, actD2_q, pendD1_q, pendD2_q;
    logic [DIAP_WIDTH-1:0] actDiap_q, pendDiap_q;
    logic                  pendFull_q, overrun_q, start_q;
    logic [PAY_BITS-1:0]   payload_q;
    logic [7:0]            status_q, byte_q;
    logic [IDX_W-1:0]      idx_q;
`ifdef ADC_RESULT_TX_CHECKSUM_EN
    logic [7:0]            csum_q;
`endif
    logic [7:0]            statusByte_d, curByte_d;
    logic                  isData, arriveBusy, dropNow, txDone;

    assign isData     = (idx_q >= IDX_W'(2)) && (idx_q < DATA_END_IDX);
    assign arriveBusy = complete && (state_q != ST_IDLE);
    assign dropNow    = arriveBusy && pendFull_q;

    always_comb begin
        statusByte_d = '0;
        statusByte_d[STATUS_DIAP_LSB +: DIAP_WIDTH] = actDiap_q;
        statusByte_d[STATUS_OVERRUN_BIT]            = overrun_q;
    end

    always_comb begin
        curByte_d = ADC_FRAME_HEADER;
        if (idx_q == IDX_W'(1))
            curByte_d = status_q;
        else if (isData)
            curByte_d = payload_q[PAY_BITS-1 -: 8];
`ifdef ADC_RESULT_TX_CHECKSUM_EN
        else if (idx_q == DATA_END_IDX)
            curByte_d = csum_q;
`endif
    end

    // Arrivals outside IDLE fill the pending slot first; explicit case arms below override.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            actD1_q    <= '0;
            actD2_q    <= '0;
            actDiap_q  <= '0;
            pendD1_q   <= '0;
            pendD2_q   <= '0;
            pendDiap_q <= '0;
            pendFull_q <= 1'b0;
            overrun_q  <= 1'b0;
            start_q    <= 1'b0;
            payload_q  <= '0;
            status_q   <= '0;
            byte_q     <= '0;
            idx_q      <= '0;
`ifdef ADC_RESULT_TX_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            start_q <= 1'b0;
            if (dropNow)
                overrun_q <= 1'b1;
            else if (state_q == ST_LOAD)
                overrun_q <= 1'b0;
            if (arriveBusy && !pendFull_q) begin
                pendD1_q   <= data_in_1;
                pendD2_q   <= data_in_2;
                pendDiap_q <= diap;
                pendFull_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (pendFull_q) begin
                        actD1_q    <= pendD1_q;
                        actD2_q    <= pendD2_q;
                        actDiap_q  <= pendDiap_q;
                        pendFull_q <= complete;
                        if (complete) begin
                            pendD1_q   <= data_in_1;
                            pendD2_q   <= data_in_2;
                            pendDiap_q <= diap;
                        end
                        state_q <= ST_LOAD;
                    end else if (complete) begin
                        actD1_q   <= data_in_1;
                        actD2_q   <= data_in_2;
                        actDiap_q <= diap;
                        state_q   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    payload_q <= {WORD_BITS'(actD1_q), WORD_BITS'(actD2_q)};
                    status_q  <= statusByte_d;
                    idx_q     <= '0;
`ifdef ADC_RESULT_TX_CHECKSUM_EN
                    csum_q    <= '0;
`endif
                    state_q   <= ST_SEND;
                end
                ST_SEND: begin
                    byte_q  <= curByte_d;
                    start_q <= 1'b1;
                    if (isData)
                        payload_q <= payload_q << 8;
`ifdef ADC_RESULT_TX_CHECKSUM_EN
                    if (idx_q != '0 && idx_q < DATA_END_IDX)
                        csum_q <= csum_q + curByte_d;
`endif
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (txDone)
                        state_q <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (idx_q == LAST_IDX) begin
                        if (pendFull_q) begin
                            actD1_q    <= pendD1_q;
                            actD2_q    <= pendD2_q;
                            actDiap_q  <= pendDiap_q;
                            pendFull_q <= 1'b0;
                            state_q    <= ST_LOAD;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        idx_q   <= idx_q + IDX_W'(1);
                        state_q <= ST_SEND;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) uSer (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_q),
        .byte_in (byte_q),
        .tx      (tx),
        .done    (txDone)
    );

    assign busy    = (state_q != ST_IDLE) || pendFull_q;
    assign overrun = overrun_q;

endmodule
